// File: rtl/ahb_arb_pkg.sv
// Shared constants and types for the two-port AHB request arbiter.
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  // Beats in a burst; 0 marks an undefined-length INCR burst.
  function automatic logic [4:0] f_burst_beats(input logic [2:0] burst);
    case (burst)
      HBURST_SINGLE:               f_burst_beats = 5'd1;
      HBURST_INCR:                 f_burst_beats = 5'd0;
      HBURST_WRAP4,  HBURST_INCR4:  f_burst_beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  f_burst_beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: f_burst_beats = 5'd16;
      default:                     f_burst_beats = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// Counts burst beats and holds the arbitration lock for the length of a burst.
module ahb_burst_tracker
  import ahb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       accepted,
  input  logic [1:0] htrans,
  input  logic [2:0] burst,
  input  logic       hready,
  input  logic       hresp,
  output logic       locked,
  output logic       hold_next
);

  logic [4:0] beat_cnt;
  logic [4:0] burst_len;
  logic [4:0] cnt_nxt;
  logic [4:0] len_nxt;

  // Next lock state: start on a multi-beat NONSEQ, end on length, INCR stop, or error.
  always_comb begin
    cnt_nxt   = beat_cnt;
    len_nxt   = burst_len;
    hold_next = locked;
    if (hready) begin
      if (locked && hresp) begin
        hold_next = 1'b0;
        cnt_nxt   = 5'd0;
      end else if (locked) begin
        if (burst_len == 5'd0) begin
          if (htrans == HTRANS_IDLE || htrans == HTRANS_NONSEQ) begin
            hold_next = 1'b0;
            cnt_nxt   = 5'd0;
          end else if (accepted && beat_cnt != 5'd16) begin
            cnt_nxt = beat_cnt + 5'd1;
          end
        end else if (accepted) begin
          if (beat_cnt != 5'd16) cnt_nxt = beat_cnt + 5'd1;
          if (cnt_nxt >= burst_len) hold_next = 1'b0;
        end
      end else if (accepted && htrans == HTRANS_NONSEQ && f_burst_beats(burst) != 5'd1) begin
        hold_next = 1'b1;
        cnt_nxt   = 5'd1;
        len_nxt   = f_burst_beats(burst);
      end
    end
  end

  // Lock, beat count and burst length registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked    <= 1'b0;
      beat_cnt  <= 5'd0;
      burst_len <= 5'd0;
    end else begin
      locked    <= hold_next;
      beat_cnt  <= cnt_nxt;
      burst_len <= len_nxt;
    end
  end

endmodule

// File: rtl/ahb_req_arbiter.sv
// Round-robin arbiter sharing the AHB master adapter between CPU (m0) and DMA (m1).
module ahb_req_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [3:0]    m0_wmask,
  input  logic          m0_wen,
  input  logic          m0_ren,
  input  logic [2:0]    m0_burst,
  input  logic [1:0]    m0_htrans,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic          m0_wdone,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [3:0]    m1_wmask,
  input  logic          m1_wen,
  input  logic          m1_ren,
  input  logic [2:0]    m1_burst,
  input  logic [1:0]    m1_htrans,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic          m1_wdone,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] peri_addr,
  output logic [DW-1:0] peri_wdata,
  output logic [3:0]    peri_wmask,
  output logic          peri_wen,
  output logic          peri_ren,
  output logic [2:0]    peri_burst,
  output logic [1:0]    peri_htrans,
  input  logic          HREADY,
  input  logic          HRESP,
  input  logic [DW-1:0] HRDATA
);

  owner_t owner, owner_nxt;
  owner_t last, last_nxt;
  owner_t dph_owner;
  logic   dph_valid;
  logic   dph_write;
  logic   accepted;
  logic   locked;
  logic   hold_next;
  logic   burst_err;

  assign accepted  = HREADY && (owner != OWN_NONE) &&
                     (peri_htrans == HTRANS_NONSEQ || peri_htrans == HTRANS_SEQ);
  assign burst_err = HRESP && dph_valid && locked;

  ahb_burst_tracker u_tracker (
    .clk       (HCLK),
    .rst       (HRESET),
    .accepted  (accepted),
    .htrans    (peri_htrans),
    .burst     (peri_burst),
    .hready    (HREADY),
    .hresp     (burst_err),
    .locked    (locked),
    .hold_next (hold_next)
  );

  // Owner and round-robin history registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      owner <= OWN_NONE;
      last  <= OWN_M1;
    end else begin
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  // Re-arbitrate on ready edges that leave the bus unlocked; ties go to the port not served last.
  always_comb begin
    owner_nxt = owner;
    last_nxt  = last;
    if (HREADY && !hold_next) begin
      if (m0_req && m1_req)  owner_nxt = (last == OWN_M0) ? OWN_M1 : OWN_M0;
      else if (m0_req)       owner_nxt = OWN_M0;
      else if (m1_req)       owner_nxt = OWN_M1;
      else                   owner_nxt = OWN_NONE;
      if (owner_nxt != OWN_NONE) last_nxt = owner_nxt;
    end
  end

  // Grants and the address-phase mux; no owner drives all zeros, i.e. IDLE.
  always_comb begin
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    peri_addr   = '0;
    peri_wdata  = '0;
    peri_wmask  = '0;
    peri_wen    = 1'b0;
    peri_ren    = 1'b0;
    peri_burst  = '0;
    peri_htrans = HTRANS_IDLE;
    case (owner)
      OWN_M0: begin
        m0_gnt      = 1'b1;
        peri_addr   = m0_addr;
        peri_wdata  = m0_wdata;
        peri_wmask  = m0_wmask;
        peri_wen    = m0_wen;
        peri_ren    = m0_ren;
        peri_burst  = m0_burst;
        peri_htrans = m0_htrans;
      end
      OWN_M1: begin
        m1_gnt      = 1'b1;
        peri_addr   = m1_addr;
        peri_wdata  = m1_wdata;
        peri_wmask  = m1_wmask;
        peri_wen    = m1_wen;
        peri_ren    = m1_ren;
        peri_burst  = m1_burst;
        peri_htrans = m1_htrans;
      end
      default: ;
    endcase
  end

  // Remember who owns the data phase so returns reach the right requester.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dph_valid <= 1'b0;
      dph_owner <= OWN_NONE;
      dph_write <= 1'b0;
    end else if (HREADY) begin
      dph_valid <= accepted;
      if (accepted) begin
        dph_owner <= owner;
        dph_write <= peri_wen;
      end
    end
  end

  assign m0_rvalid = HREADY && dph_valid && (dph_owner == OWN_M0) && !dph_write;
  assign m0_wdone  = HREADY && dph_valid && (dph_owner == OWN_M0) && dph_write;
  assign m0_err    = HRESP && dph_valid && (dph_owner == OWN_M0);
  assign m1_rvalid = HREADY && dph_valid && (dph_owner == OWN_M1) && !dph_write;
  assign m1_wdone  = HREADY && dph_valid && (dph_owner == OWN_M1) && dph_write;
  assign m1_err    = HRESP && dph_valid && (dph_owner == OWN_M1);
  assign m0_rdata  = HRDATA;
  assign m1_rdata  = HRDATA;

endmodule
